// File: rtl/data_memory_bank.sv
// Parametrised CPU data memory with byte-enable writes, optional registered read,
// a sequential clear engine and CPU/test-port collision reporting.
module data_memory_bank #(
   parameter int LENGTH         = 16,
   parameter int DATA_MEM_DEPTH = 256,
   parameter int BYTE_W         = 8,
   parameter int READ_LATENCY   = 1,
   localparam int AW = (DATA_MEM_DEPTH > 1) ? $clog2(DATA_MEM_DEPTH) : 1,
   localparam int NB = LENGTH / BYTE_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear_req,
   output logic              mem_busy,
   input  logic              test_normal,
   input  logic              ext_DM_we,
   input  logic [LENGTH-1:0] ext_data,
   input  logic [AW-1:0]     ext_addr,
   output logic              ext_conflict,
   input  logic              writeMem,
   input  logic [NB-1:0]     byteEn,
   input  logic [LENGTH-1:0] writeData,
   input  logic [AW-1:0]     dataAddr,
   input  logic              readMem,
   output logic [LENGTH-1:0] mem_data_out,
   output logic              mem_data_valid
);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DATA_MEM_DEPTH);
   localparam logic [AW:0] LAST_W  = (AW + 1)'(DATA_MEM_DEPTH - 1);
   localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

   state_t            state, next_state;
   logic [AW:0]       clr_addr, next_clr_addr;
   logic [LENGTH-1:0] mem [DATA_MEM_DEPTH];

   logic              cpu_in_range, ext_in_range, ext_go;
   logic [LENGTH-1:0] rd_word;
   logic [NB-1:0]     lane_we;
   logic [AW-1:0]     wr_addr;
   logic [LENGTH-1:0] wr_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= next_state;
         clr_addr <= next_clr_addr;
      end
   end

   always_comb begin
      next_state    = state;
      next_clr_addr = clr_addr;
      case (state)
         IDLE: begin
            if (clear_req) begin
               next_state    = CLEAR;
               next_clr_addr = '0;
            end
         end
         CLEAR: begin
            // clr_addr is one bit wider than AW so the last index compares exactly
            if (clr_addr == LAST_W) begin
               next_state    = IDLE;
               next_clr_addr = '0;
            end else begin
               next_clr_addr = clr_addr + ONE_W;
            end
         end
         default: next_state = CLEAR;
      endcase
   end

   assign mem_busy     = (state == CLEAR);
   assign cpu_in_range = ({1'b0, dataAddr} < DEPTH_W);
   assign ext_in_range = ({1'b0, ext_addr} < DEPTH_W);
   assign ext_go       = test_normal && ext_DM_we && !writeMem;
   assign rd_word      = cpu_in_range ? mem[dataAddr] : '0;

   // One write port per cycle: clear walk, then CPU, then the external loader.
   always_comb begin
      lane_we = '0;
      wr_addr = dataAddr;
      wr_data = writeData;
      if (mem_busy) begin
         lane_we = '1;
         wr_addr = clr_addr[AW-1:0];
         wr_data = '0;
      end else if (writeMem) begin
         if (cpu_in_range) lane_we = byteEn;
      end else if (ext_go) begin
         if (ext_in_range) lane_we = '1;
         wr_addr = ext_addr;
         wr_data = ext_data;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NB; k++) begin
         if (lane_we[k]) mem[wr_addr][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ext_conflict <= 1'b0;
      else          ext_conflict <= !mem_busy && test_normal && ext_DM_we && writeMem;
   end

   generate
      if (READ_LATENCY == 0) begin : g_comb_read
         always_comb begin
            mem_data_valid = readMem && !writeMem && !mem_busy;
            mem_data_out   = mem_data_valid ? rd_word : '0;
         end
      end else begin : g_reg_read
         logic [LENGTH-1:0] mask, merged;

         always_comb begin
            mask = '0;
            for (int k = 0; k < NB; k++) mask[k*BYTE_W +: BYTE_W] = {BYTE_W{byteEn[k]}};
            merged = (rd_word & ~mask) | (writeData & mask);
         end

         // Write-first: a same-edge CPU write is folded into the registered word.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               mem_data_out   <= '0;
               mem_data_valid <= 1'b0;
            end else if (mem_busy) begin
               mem_data_out   <= '0;
               mem_data_valid <= 1'b0;
            end else if (readMem) begin
               mem_data_valid <= 1'b1;
               if (!cpu_in_range) mem_data_out <= '0;
               else if (writeMem) mem_data_out <= merged;
               else               mem_data_out <= rd_word;
            end else begin
               mem_data_valid <= 1'b0;
            end
         end
      end
   endgenerate

endmodule
